// File: rtl/poc_controller.sv
// Parallel output controller: status bits, byte buffer and a
// strobe/ready printer handshake with timeout.
module poc_controller #(
   parameter int TR_PULSE = 4,
   parameter int TIMEOUT  = 100000,
   parameter int TO_W     = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] din,
   input  logic       rw,
   input  logic       reg_in,
   input  logic [2:0] addr,
   output logic       reg_out,
   output logic       irq,
   output logic [7:0] pd,
   output logic       tr,
   input  logic       rdy
);

   localparam int PW = (TR_PULSE > 1) ? $clog2(TR_PULSE) : 1;
   localparam logic [PW-1:0] PULSE_LAST = PW'(TR_PULSE - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      WAIT_BUSY,
      WAIT_READY,
      DONE
   } state_e;

   state_e          state_q, state_d;
   logic            sr0_q, sr0_d;
   logic            sr6_q, sr6_d;
   logic            sr7_q, sr7_d;
   logic [7:0]      br_q, br_d;
   logic [7:0]      pd_q, pd_d;
   logic            tr_q, tr_d;
   logic            irq_q, irq_d;
   logic            reg_out_q, reg_out_d;
   logic [PW-1:0]   pulse_q, pulse_d;
   logic [TO_W-1:0] to_q, to_d;
   logic            time_out;

   always_comb begin
      state_d   = state_q;
      sr0_d     = sr0_q;
      sr6_d     = sr6_q;
      sr7_d     = sr7_q;
      br_d      = br_q;
      pd_d      = pd_q;
      pulse_d   = pulse_q;
      to_d      = to_q;
      time_out  = 1'b0;
      reg_out_d = 1'b0;

      if (rw) begin
         case (addr)
            3'b000: sr0_d = reg_in;
            3'b001: br_d  = din;
            3'b110: sr6_d = reg_in;
            3'b111: if (state_q == IDLE) sr7_d = reg_in;
            default: ;
         endcase
      end

      case (state_q)
         IDLE: begin
            if (!sr7_q && rdy) begin
               pd_d    = br_q;
               state_d = SETUP;
            end
         end
         SETUP: begin
            pulse_d = '0;
            state_d = STROBE;
         end
         STROBE: begin
            if (pulse_q == PULSE_LAST) begin
               to_d    = '0;
               state_d = WAIT_BUSY;
            end else begin
               pulse_d = pulse_q + 1'b1;
            end
         end
         WAIT_BUSY: begin
            to_d = to_q + 1'b1;
            if (!rdy) state_d = WAIT_READY;
            else if (to_q == TO_LAST) time_out = 1'b1;
         end
         WAIT_READY: begin
            to_d = to_q + 1'b1;
            if (rdy) state_d = DONE;
            else if (to_q == TO_LAST) time_out = 1'b1;
         end
         DONE: begin
            sr7_d   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // The controller's own status updates beat a same-cycle write.
      if (time_out) begin
         sr6_d   = 1'b1;
         sr7_d   = 1'b1;
         state_d = IDLE;
      end

      case (addr)
         3'b000:  reg_out_d = sr0_q;
         3'b110:  reg_out_d = sr6_q;
         3'b111:  reg_out_d = sr7_q;
         default: reg_out_d = 1'b0;
      endcase

      irq_d = ~(sr0_q & sr7_q);
      tr_d  = (state_d == STROBE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sr0_q     <= 1'b0;
         sr6_q     <= 1'b0;
         sr7_q     <= 1'b1;
         br_q      <= 8'h00;
         pd_q      <= 8'h00;
         tr_q      <= 1'b0;
         irq_q     <= 1'b1;
         reg_out_q <= 1'b0;
         pulse_q   <= '0;
         to_q      <= '0;
      end else begin
         state_q   <= state_d;
         sr0_q     <= sr0_d;
         sr6_q     <= sr6_d;
         sr7_q     <= sr7_d;
         br_q      <= br_d;
         pd_q      <= pd_d;
         tr_q      <= tr_d;
         irq_q     <= irq_d;
         reg_out_q <= reg_out_d;
         pulse_q   <= pulse_d;
         to_q      <= to_d;
      end
   end

   assign reg_out = reg_out_q;
   assign irq     = irq_q;
   assign pd      = pd_q;
   assign tr      = tr_q;

endmodule

// File: tb/tb_poc_controller.sv
// Bench for poc_controller: directed scenarios plus random traffic,
// all checked against a transaction-level model of the controller.
module tb_poc_controller;

   localparam int TRP = 4;
   localparam int TMO = 40;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] din;
   logic       rw;
   logic       reg_in;
   logic [2:0] addr;
   logic       reg_out;
   logic       irq;
   logic [7:0] pd;
   logic       tr;
   logic       rdy;

   int checks = 0;
   int errors = 0;

   poc_controller #(
      .TR_PULSE(TRP),
      .TIMEOUT (TMO),
      .TO_W    (8)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (din),
      .rw     (rw),
      .reg_in (reg_in),
      .addr   (addr),
      .reg_out(reg_out),
      .irq    (irq),
      .pd     (pd),
      .tr     (tr),
      .rdy    (rdy)
   );

   always #5 clk = ~clk;

   // reference model state
   logic       m_sr0, m_sr6, m_sr7;
   logic [7:0] m_br, m_pd;
   logic       m_reg_out, m_irq, m_tr;
   logic       m_busy, m_done, m_low;
   int         m_t, m_w;

   // printer and observation state
   int         pmode;
   logic       p_act;
   int         p_cnt;
   logic       tr_prev;
   logic [7:0] pd_prev;
   int         tr_len, last_tr_len;
   logic [7:0] last_pd_pre;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      m_sr0 = 0; m_sr6 = 0; m_sr7 = 1;
      m_br = 8'h00; m_pd = 8'h00;
      m_reg_out = 0; m_irq = 1; m_tr = 0;
      m_busy = 0; m_done = 0; m_low = 0;
      m_t = 0; m_w = 0;
      p_act = 0; p_cnt = 0;
      tr_prev = 0; pd_prev = 8'h00;
      tr_len = 0; last_tr_len = 0; last_pd_pre = 8'h00;
   endtask

   task automatic m_step(input logic w, input logic [2:0] a,
                         input logic [7:0] d, input logic ri,
                         input logic r);
      logic       o_sr0, o_sr6, o_sr7, o_busy, o_done, o_low;
      logic [7:0] o_br;
      int         o_t, o_w;
      o_sr0 = m_sr0; o_sr6 = m_sr6; o_sr7 = m_sr7; o_br = m_br;
      o_busy = m_busy; o_done = m_done; o_low = m_low;
      o_t = m_t; o_w = m_w;
      m_reg_out = (a == 3'd0) ? o_sr0 :
                  (a == 3'd6) ? o_sr6 :
                  (a == 3'd7) ? o_sr7 : 1'b0;
      m_irq = !(o_sr0 && o_sr7);
      if (w) begin
         if (a == 3'd0) m_sr0 = ri;
         if (a == 3'd1) m_br = d;
         if (a == 3'd6) m_sr6 = ri;
         if (a == 3'd7 && !o_busy) m_sr7 = ri;
      end
      if (!o_busy) begin
         if (!o_sr7 && r) begin
            m_busy = 1; m_t = 0; m_pd = o_br;
            m_low = 0; m_w = 0; m_done = 0;
         end
      end else if (o_done) begin
         m_busy = 0; m_done = 0; m_sr7 = 1;
      end else begin
         m_t = o_t + 1;
         if (o_t >= TRP + 1) begin
            m_w = o_w + 1;
            if (!o_low && !r) m_low = 1;
            else if (o_low && r) m_done = 1;
            else if (o_w == TMO - 1) begin
               m_sr6 = 1; m_sr7 = 1; m_busy = 0;
            end
         end
      end
      m_tr = m_busy && !m_done && m_t >= 1 && m_t <= TRP;
   endtask

   task automatic cycle(input logic w, input logic [2:0] a,
                        input logic [7:0] d, input logic ri);
      logic r;
      @(negedge clk);
      r = 1'b1;
      if (pmode == 1) begin
         p_cnt++;
         r = !(p_act && p_cnt >= 2 && p_cnt < 12);
         if (p_cnt >= 12) p_act = 0;
      end else if (pmode == 2) begin
         r = ($urandom_range(3) != 0);
      end
      rw = w; addr = a; din = d; reg_in = ri; rdy = r;
      @(posedge clk);
      m_step(w, a, d, ri, r);
      #1;
      chk("reg_out", 32'(reg_out), 32'(m_reg_out));
      chk("irq", 32'(irq), 32'(m_irq));
      chk("tr", 32'(tr), 32'(m_tr));
      chk("pd", 32'(pd), 32'(m_pd));
      if (tr && !tr_prev) begin
         last_pd_pre = pd_prev;
         tr_len = 0;
      end
      if (tr) tr_len++;
      if (!tr && tr_prev) begin
         last_tr_len = tr_len;
         p_act = 1;
         p_cnt = 0;
      end
      tr_prev = tr;
      pd_prev = pd;
   endtask

   task automatic run_until_idle(input string tag, input int max);
      int n;
      n = 0;
      do begin
         cycle(1'b0, 3'd7, 8'h00, 1'b0);
         n++;
      end while (!(!m_busy && m_sr7) && n < max);
      chk(tag, 32'(!m_busy && m_sr7), 32'd1);
   endtask

   initial begin
      int n;
      rst_n = 0; rw = 0; addr = 0; din = 0; reg_in = 0; rdy = 1;
      pmode = 0;
      m_reset();
      #12;
      chk("rst_reg_out", 32'(reg_out), 32'd0);
      chk("rst_irq", 32'(irq), 32'd1);
      chk("rst_tr", 32'(tr), 32'd0);
      chk("rst_pd", 32'(pd), 32'd0);
      @(posedge clk);
      #1 rst_n = 1;

      cycle(1'b0, 3'd7, 8'h00, 1'b0);
      chk("rst_sr7", 32'(reg_out), 32'd1);
      cycle(1'b0, 3'd0, 8'h00, 1'b0);
      chk("rst_sr0", 32'(reg_out), 32'd0);

      // polling transfer
      pmode = 1;
      cycle(1'b1, 3'd1, 8'h48, 1'b0);
      cycle(1'b1, 3'd7, 8'h00, 1'b0);
      run_until_idle("poll_done", 200);
      chk("tr_width", 32'(last_tr_len), 32'(TRP));
      chk("pd_pre_tr", 32'(last_pd_pre), 32'h48);
      chk("poll_pd", 32'(pd), 32'h48);

      // interrupt mode
      cycle(1'b1, 3'd0, 8'h00, 1'b1);
      cycle(1'b0, 3'd7, 8'h00, 1'b0);
      chk("irq_lo", 32'(irq), 32'd0);
      cycle(1'b1, 3'd7, 8'h00, 1'b0);
      cycle(1'b0, 3'd7, 8'h00, 1'b0);
      chk("irq_hi", 32'(irq), 32'd1);
      run_until_idle("irq_done", 200);
      cycle(1'b0, 3'd7, 8'h00, 1'b0);
      chk("irq_lo2", 32'(irq), 32'd0);
      cycle(1'b1, 3'd0, 8'h00, 1'b0);

      // printer stuck ready
      pmode = 0;
      cycle(1'b1, 3'd7, 8'h00, 1'b0);
      run_until_idle("stuck_done", 200);
      cycle(1'b0, 3'd6, 8'h00, 1'b0);
      chk("to_sr6", 32'(reg_out), 32'd1);
      cycle(1'b0, 3'd7, 8'h00, 1'b0);
      chk("to_sr7", 32'(reg_out), 32'd1);
      cycle(1'b1, 3'd6, 8'h00, 1'b0);
      cycle(1'b0, 3'd6, 8'h00, 1'b0);
      chk("sr6_clr", 32'(reg_out), 32'd0);

      // busy protection
      pmode = 1;
      cycle(1'b1, 3'd7, 8'h00, 1'b0);
      n = 0;
      while (!(m_busy && m_low) && n < 100) begin
         cycle(1'b0, 3'd7, 8'h00, 1'b0);
         n++;
      end
      chk("reach_wait_ready", 32'(m_busy && m_low), 32'd1);
      cycle(1'b1, 3'd7, 8'h00, 1'b1);
      cycle(1'b1, 3'd1, 8'h65, 1'b0);
      chk("pd_hold", 32'(pd), 32'h48);
      cycle(1'b0, 3'd7, 8'h00, 1'b0);
      chk("sr7_busy", 32'(reg_out), 32'd0);
      run_until_idle("prot_done", 200);
      chk("pd_after", 32'(pd), 32'h48);
      cycle(1'b1, 3'd7, 8'h00, 1'b0);
      run_until_idle("next_done", 200);
      chk("pd_next", 32'(pd), 32'h65);

      // reset in the middle of the strobe
      pmode = 0;
      cycle(1'b1, 3'd1, 8'h5a, 1'b0);
      cycle(1'b1, 3'd7, 8'h00, 1'b0);
      n = 0;
      while (!m_tr && n < 20) begin
         cycle(1'b0, 3'd7, 8'h00, 1'b0);
         n++;
      end
      chk("reach_strobe", 32'(tr), 32'd1);
      rst_n = 0;
      #1;
      chk("mid_rst_tr", 32'(tr), 32'd0);
      chk("mid_rst_pd", 32'(pd), 32'd0);
      chk("mid_rst_irq", 32'(irq), 32'd1);
      m_reset();
      @(posedge clk);
      #1 rst_n = 1;
      cycle(1'b0, 3'd7, 8'h00, 1'b0);
      chk("mid_rst_sr7", 32'(reg_out), 32'd1);
      cycle(1'b1, 3'd1, 8'h3c, 1'b0);
      cycle(1'b1, 3'd7, 8'h00, 1'b0);
      run_until_idle("post_rst_done", 200);
      chk("post_rst_pd", 32'(pd), 32'h3c);

      // random traffic
      pmode = 2;
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(2) == 0), 3'($urandom_range(7)),
               8'($urandom), 1'($urandom_range(1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

endmodule
